// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT/IFFT family: defaults, twiddle table,
// bit-reversal helper and the frame-level state encoding.
package fft_pkg;

    localparam int FFT_DW = 16;
    localparam int FFT_TW = 16;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } tw_q14_t;

    // Conjugate twiddles W8^-t in Q1.14, used by the inverse transform.
    function automatic tw_q14_t ifft_twiddle(input logic [1:0] t);
        tw_q14_t w;
        case (t)
            2'd0:    w = '{re: 16'sd16384,  im: 16'sd0};
            2'd1:    w = '{re: 16'sd11585,  im: 16'sd11585};
            2'd2:    w = '{re: 16'sd0,      im: 16'sd16384};
            default: w = '{re: -16'sd11585, im: 16'sd11585};
        endcase
        return w;
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_bfly.sv
// Combinational radix-2 butterfly: x = (a + b*w)/2, y = (a - b*w)/2,
// with rounded product and saturation back to DW bits.
module fft_bfly #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
);

    localparam int PW = DW + TW + 1;
    localparam int SW = DW + 2;
    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (TW - 3);
    localparam logic signed [SW-1:0] SMAX = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (DW - 1)));

    function automatic logic signed [DW-1:0] half_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] h;
        h = s >>> 1;
        if (h > SMAX)      return DW'(SMAX);
        else if (h < SMIN) return DW'(SMIN);
        else               return DW'(h);
    endfunction

    logic signed [PW-1:0] prod_re, prod_im, rnd_re, rnd_im;
    logic signed [SW-1:0] p_re, p_im;

    // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
    always_comb begin
        prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        rnd_re  = (prod_re + RND) >>> (TW - 2);
        rnd_im  = (prod_im + RND) >>> (TW - 2);
        // |b*w| < 1.5 * 2^(DW-1), so the rounded product fits comfortably in SW bits.
        p_re    = SW'(rnd_re);
        p_im    = SW'(rnd_im);
        x_re    = half_sat(SW'(a_re) + p_re);
        x_im    = half_sat(SW'(a_im) + p_im);
        y_re    = half_sat(SW'(a_re) - p_re);
        y_im    = half_sat(SW'(a_im) - p_im);
    end

endmodule

// File: rtl/ifft8_stream.sv
// 8-point radix-2 DIT inverse FFT with one time-shared butterfly, streaming
// load/unload over valid/ready and overall 1/8 scaling.
module ifft8_stream
    import fft_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int TW = FFT_TW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 busy
);

    state_t               state;
    logic [2:0]           ld_cnt, out_cnt;
    logic [1:0]           stg, bfi;
    logic signed [DW-1:0] mem_re [8];
    logic signed [DW-1:0] mem_im [8];

    logic [2:0]           span, top_a, bot_a;
    logic [1:0]           tidx;
    tw_q14_t              w14;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [DW-1:0] x_re, x_im, y_re, y_im;

    always_comb begin
        span  = 3'd1 << stg;
        top_a = ((3'(bfi) >> stg) << (stg + 2'd1)) | (3'(bfi) & (span - 3'd1));
        bot_a = top_a + span;
        tidx  = 2'((3'(bfi) & (span - 3'd1)) << (2'd2 - stg));
        w14   = ifft_twiddle(tidx);
    end

    // The table is Q1.14; rescale to Q1.(TW-2) when a different twiddle width is used.
    if (TW >= 16) begin : g_tw_wide
        assign w_re = TW'(w14.re) <<< (TW - 16);
        assign w_im = TW'(w14.im) <<< (TW - 16);
    end else begin : g_tw_narrow
        assign w_re = TW'(w14.re >>> (16 - TW));
        assign w_im = TW'(w14.im >>> (16 - TW));
    end

    fft_bfly #(.DW(DW), .TW(TW)) u_bfly (
        .a_re (mem_re[top_a]),
        .a_im (mem_im[top_a]),
        .b_re (mem_re[bot_a]),
        .b_im (mem_im[bot_a]),
        .w_re (w_re),
        .w_im (w_im),
        .x_re (x_re),
        .x_im (x_im),
        .y_re (y_re),
        .y_im (y_im)
    );

    // NOTE: non-blocking assignments keep every state update based on pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            ld_cnt  <= '0;
            out_cnt <= '0;
            stg     <= '0;
            bfi     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        ld_cnt <= ld_cnt + 3'd1;
                        if (ld_cnt == 3'd7) state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    bfi <= bfi + 2'd1;
                    if (bfi == 2'd3) begin
                        if (stg == 2'd2) begin
                            stg   <= '0;
                            state <= UNLOAD;
                        end else begin
                            stg <= stg + 2'd1;
                        end
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        out_cnt <= out_cnt + 3'd1;
                        if (out_cnt == 3'd7) state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // NOTE: the sample buffer is plain storage and deliberately has no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem_re[bitrev3(ld_cnt)] <= in_re;
            mem_im[bitrev3(ld_cnt)] <= in_im;
        end else if (state == COMPUTE) begin
            mem_re[top_a] <= x_re;
            mem_im[top_a] <= x_im;
            mem_re[bot_a] <= y_re;
            mem_im[bot_a] <= y_im;
        end
    end

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign out_valid = (state == UNLOAD);
    assign out_last  = out_valid && (out_cnt == 3'd7);
    assign out_re    = out_valid ? mem_re[out_cnt] : '0;
    assign out_im    = out_valid ? mem_im[out_cnt] : '0;

endmodule

// File: tb/tb_ifft8_stream.sv
// Directed and random-frame bench for ifft8_stream: impulse, tone, DC, stall,
// latency, mid-compute reset and comparison against a floating-point IFFT/8.
module tb_ifft8_stream;

    localparam int DW = 16;
    localparam int TW = 16;
    localparam real PI = 3.14159265358979;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready;
    logic signed [DW-1:0] in_re, in_im;
    logic                 out_valid, out_ready;
    logic signed [DW-1:0] out_re, out_im;
    logic                 out_last, busy;

    int   total = 0;
    int   bad   = 0;
    int   fr_re [8];
    int   fr_im [8];
    int   got_re [8];
    int   got_im [8];
    logic got_last [8];

    ifft8_stream #(.DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input real exp, input real tol);
        real d;
        d = real'(obs) - exp;
        if (d < 0.0) d = -d;
        total++;
        assert (d <= tol) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0.2f tol=%0.1f", tag, obs, exp, tol);
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 0;
            fr_im[k] = 0;
        end
    endtask

    // Drives 8 bins; with hold_valid, keeps in_valid high with junk through
    // COMPUTE and checks the out_valid rise cycle.
    task automatic send_frame(input bit hold_valid);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re    = DW'(fr_re[k]);
            in_im    = DW'(fr_im[k]);
            check_bit($sformatf("in_ready_bin%0d", k), in_ready, 1'b1);
        end
        @(negedge clk);
        if (hold_valid) begin
            in_re = 16'sd12345;
            in_im = -16'sd12345;
            for (int i = 1; i <= 12; i++) begin
                check_bit($sformatf("out_valid_low_c%0d", i), out_valid, 1'b0);
                check_bit($sformatf("in_ready_low_c%0d", i), in_ready, 1'b0);
                @(negedge clk);
            end
            check_bit("out_valid_rise_c13", out_valid, 1'b1);
            check_bit("busy_c13", busy, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    // Collects 8 samples; stall_n >= 0 holds out_ready low for 5 cycles on that sample.
    task automatic recv_frame(input int stall_n);
        int cnt;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cnt = 0;
            while (!out_valid && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            if (!out_valid) begin
                check_bit($sformatf("out_valid_timeout_n%0d", n), out_valid, 1'b1);
                return;
            end
            got_re[n]   = out_re;
            got_im[n]   = out_im;
            got_last[n] = out_last;
            if (n == stall_n) begin
                out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check_bit($sformatf("stall_valid_%0d", j), out_valid, 1'b1);
                    check_near($sformatf("stall_re_%0d", j), out_re, real'(got_re[n]), 0.0);
                    check_near($sformatf("stall_im_%0d", j), out_im, real'(got_im[n]), 0.0);
                    check_bit($sformatf("stall_in_ready_%0d", j), in_ready, 1'b0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check_bit("in_ready_after_unload", in_ready, 1'b1);
        check_bit("out_valid_after_unload", out_valid, 1'b0);
        check_near("out_re_idle", out_re, 0.0, 0.0);
    endtask

    task automatic check_impulse(input string tag);
        for (int n = 0; n < 8; n++) begin
            check_near($sformatf("%s_re_n%0d", tag, n), got_re[n], 1000.0, 1.0);
            check_near($sformatf("%s_im_n%0d", tag, n), got_im[n], 0.0, 1.0);
            check_bit($sformatf("%s_last_n%0d", tag, n), got_last[n], (n == 7));
        end
    endtask

    int  tone_re [8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    int  tone_im [8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};
    real mr, mi, ang;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_out_last", out_last, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_near("rst_out_re", out_re, 0.0, 0.0);
        check_near("rst_out_im", out_im, 0.0, 0.0);
        rst = 1'b0;

        // Impulse at bin 0, with latency check, junk held on in_valid and a stall on n=3.
        clear_frame();
        fr_re[0] = 8000;
        send_frame(1'b1);
        recv_frame(3);
        check_impulse("imp");

        // Single tone at bin 1.
        clear_frame();
        fr_re[1] = 8000;
        send_frame(1'b0);
        recv_frame(-1);
        for (int n = 0; n < 8; n++) begin
            check_near($sformatf("tone_re_n%0d", n), got_re[n], real'(tone_re[n]), 2.0);
            check_near($sformatf("tone_im_n%0d", n), got_im[n], real'(tone_im[n]), 2.0);
        end

        // Flat spectrum -> impulse at n=0.
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 800;
            fr_im[k] = 0;
        end
        send_frame(1'b0);
        recv_frame(-1);
        for (int n = 0; n < 8; n++) begin
            check_near($sformatf("dc_re_n%0d", n), got_re[n], (n == 0) ? 800.0 : 0.0, 1.0);
            check_near($sformatf("dc_im_n%0d", n), got_im[n], 0.0, 1.0);
        end

        // Reset during COMPUTE cycle 6, then a fresh frame.
        clear_frame();
        fr_re[1] = 8000;
        send_frame(1'b0);
        repeat (5) @(negedge clk);
        check_bit("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        clear_frame();
        fr_re[0] = 8000;
        send_frame(1'b0);
        recv_frame(-1);
        check_impulse("post_rst");

        // Random frames against a floating-point IFFT/8.
        for (int f = 0; f < 200; f++) begin
            for (int k = 0; k < 8; k++) begin
                fr_re[k] = int'($urandom_range(32766)) - 16383;
                fr_im[k] = int'($urandom_range(32766)) - 16383;
            end
            send_frame(1'b0);
            recv_frame(-1);
            for (int n = 0; n < 8; n++) begin
                mr = 0.0;
                mi = 0.0;
                for (int k = 0; k < 8; k++) begin
                    ang = 2.0 * PI * real'(k * n) / 8.0;
                    mr  = mr + real'(fr_re[k]) * $cos(ang) - real'(fr_im[k]) * $sin(ang);
                    mi  = mi + real'(fr_re[k]) * $sin(ang) + real'(fr_im[k]) * $cos(ang);
                end
                check_near($sformatf("rnd%0d_re_n%0d", f, n), got_re[n], mr / 8.0, 3.0);
                check_near($sformatf("rnd%0d_im_n%0d", f, n), got_im[n], mi / 8.0, 3.0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
